// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared FSM states, config register addresses and default prescale for pulse_gen
// Optional macro PULSE_GEN_DELAY_EN adds the DELAY state.
package pulse_gen_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
`ifdef PULSE_GEN_DELAY_EN
    S_DELAY,
`endif
    S_HIGH,
    S_LOW,
    S_FIN
  } state_t;
  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_DELAY  = 2'd3;
  localparam int DEF_CLK_DIV = 50;
endpackage

// File: rtl/pulse_gen_tick_div.sv
// tick_div: prescaler giving a one-clk tick every CLK_DIV clocks, restarted by clr
// Ports: clk, rst (sync, active-high), clr (restart count), tick (one-clk strobe).
module tick_div import pulse_gen_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [15:0] r_cnt;
  assign tick = r_cnt == 16'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: configurable optical sync pulse-train generator
// Ports: clk, rst (sync, active-high); cfg_we/cfg_addr/cfg_data write PERIOD, WIDTH, COUNT, DELAY;
// start/stop request or abort a train; pulse_out, busy, done, pulse_cnt report the train.
// Optional macro PULSE_GEN_DELAY_EN adds the DELAY register and state.
module pulse_gen import pulse_gen_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         start,
  input  logic         stop,
  output logic         pulse_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pulse_cnt
);
  state_t       r_state;
  logic [W-1:0] r_period, r_width, r_count;
  logic [W-1:0] r_sh_period, r_sh_width, r_sh_count;
  logic [W-1:0] r_cnt, r_tcnt;
  logic         r_pulse, r_busy, r_done;
  logic         w_tick, w_accept, w_run, w_last, w_ps_pulse;
  logic [W-1:0] w_width_c, w_wsrc, w_target, w_cnt_inc;
  state_t       w_ps_state;

  tick_div #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .clr(w_accept), .tick(w_tick));

  always_ff @(posedge clk)
    if (rst) begin
      r_period <= '0;
      r_width  <= '0;
      r_count  <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_PERIOD) r_period <= cfg_data;
      if (cfg_addr == ADDR_WIDTH) r_width <= cfg_data;
      if (cfg_addr == ADDR_COUNT) r_count <= cfg_data;
    end

  always_ff @(posedge clk)
    if (rst) begin
      r_sh_period <= '0;
      r_sh_width  <= '0;
      r_sh_count  <= '0;
    end else if (w_accept) begin
      r_sh_period <= r_period;
      r_sh_width  <= w_width_c;
      r_sh_count  <= r_count;
    end

`ifdef PULSE_GEN_DELAY_EN
  logic [W-1:0] r_delay, r_sh_delay;
  always_ff @(posedge clk)
    if (rst) r_delay <= '0;
    else if (cfg_we && cfg_addr == ADDR_DELAY) r_delay <= cfg_data;
  always_ff @(posedge clk)
    if (rst) r_sh_delay <= '0;
    else if (w_accept) r_sh_delay <= r_delay;
  assign w_target = r_state == S_HIGH ? r_sh_width :
                    r_state == S_LOW  ? r_sh_period - r_sh_width : r_sh_delay;
`else
  assign w_target = r_state == S_HIGH ? r_sh_width : r_sh_period - r_sh_width;
`endif

  assign w_accept   = r_state == S_IDLE && start && !stop && r_period != '0;
  assign w_run      = r_state != S_IDLE && r_state != S_FIN;
  assign w_width_c  = r_width >= r_period ? r_period - W'(1) : r_width;
  assign w_last     = w_tick && r_tcnt == w_target - W'(1);
  // A period starting from IDLE must use the live config, since the shadows load on the same edge.
  assign w_wsrc     = r_state == S_IDLE ? w_width_c : r_sh_width;
  assign w_ps_state = w_wsrc == '0 ? S_LOW : S_HIGH;
  assign w_ps_pulse = w_wsrc != '0;
  assign w_cnt_inc  = r_state == S_IDLE ? W'(1) : &r_cnt ? r_cnt : r_cnt + W'(1);

  // Outputs are registered together with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (stop && w_run) begin
        r_state <= S_FIN;
        r_pulse <= 1'b0;
      end else begin
        if (w_tick) r_tcnt <= r_tcnt + W'(1);
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_busy  <= 1'b1;
            r_tcnt  <= '0;
            r_state <= w_ps_state;
            r_pulse <= w_ps_pulse;
            r_cnt   <= w_cnt_inc;
`ifdef PULSE_GEN_DELAY_EN
            if (r_delay != '0) begin
              r_state <= S_DELAY;
              r_pulse <= 1'b0;
              r_cnt   <= '0;
            end
`endif
          end
`ifdef PULSE_GEN_DELAY_EN
          S_DELAY: if (w_last) begin
            r_state <= w_ps_state;
            r_pulse <= w_ps_pulse;
            r_cnt   <= w_cnt_inc;
            r_tcnt  <= '0;
          end
`endif
          S_HIGH: if (w_last) begin
            r_state <= S_LOW;
            r_pulse <= 1'b0;
            r_tcnt  <= '0;
          end
          S_LOW: if (w_last) begin
            if (r_sh_count != '0 && r_cnt == r_sh_count) r_state <= S_FIN;
            else begin
              r_state <= w_ps_state;
              r_pulse <= w_ps_pulse;
              r_cnt   <= w_cnt_inc;
              r_tcnt  <= '0;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_cnt;
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: self-checking bench for pulse_gen with CLK_DIV=2
module tb_pulse_gen;
  localparam int D = 2;
  typedef struct packed { logic p; logic b; logic d; logic [7:0] c; } outs_t;
  typedef struct { int period; int width; int count; int hi; int lo; int n; } vec_t;

  logic       clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       pulse_out, busy, done;
  logic [7:0] pulse_cnt;
  int         n_chk = 0, n_fail = 0;
  outs_t      sb[$];

  pulse_gen #(.CLK_DIV(D), .W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .pulse_out(pulse_out), .busy(busy), .done(done),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return x > 255 ? 255 : x;
  endfunction

  function automatic outs_t mk(input logic p, input logic b, input logic d, input int c);
    return {p, b, d, 8'(c)};
  endfunction

  // Expected outputs j clocks after the start edge: off clocks of delay, then periods of
  // hi+lo ticks (hi ticks high), ending after n periods or at the stop edge stop_j.
  function automatic outs_t model(input int j, input int hi, input int lo, input int n,
                                  input int off, input int stop_j);
    int l, e;
    l = (hi + lo) * D;
    e = stop_j >= 0 ? stop_j : off + n * l;
    if (j < off) return mk(1'b0, 1'b1, 1'b0, 0);
    if (j < e) return mk((j - off) % l < hi * D, 1'b1, 1'b0, sat((j - off) / l + 1));
    return mk(1'b0, j == e, j == e + 1, sat((e - 1 - off) / l + 1));
  endfunction

  task automatic chk(input string nm, input outs_t e);
    outs_t a;
    a = {pulse_out, busy, done, pulse_cnt};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got pulse=%b busy=%b done=%b cnt=%0d, want pulse=%b busy=%b done=%b cnt=%0d",
               nm, $time, a.p, a.b, a.d, a.c, e.p, e.b, e.d, e.c);
    end
  endtask

  task automatic wr(input logic [1:0] a, input int v);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = 8'(v);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int p, input int w, input int c);
    wr(2'd0, p);
    wr(2'd1, w);
    wr(2'd2, c);
  endtask

  // Drives one train; start_j/stop_j/wr_j are the edges (after the start edge) at which an
  // extra start, a stop, or a WIDTH write are sampled (-1 for none).
  task automatic run(input string nm, input int hi, input int lo, input int n, input int off,
                     input int stop_j, input int start_j, input int wr_j, input int wr_v);
    int last;
    last = (stop_j >= 0 ? stop_j : off + n * (hi + lo) * D) + 2;
    for (int j = 0; j <= last; j++) sb.push_back(model(j, hi, lo, n, off, stop_j));
    start = 1'b1;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      start = j + 1 == start_j;
      stop = j + 1 == stop_j;
      cfg_we = j + 1 == wr_j;
      cfg_addr = 2'd1;
      cfg_data = 8'(wr_v);
      chk(nm, sb.pop_front());
    end
  endtask

  initial begin
    vec_t tbl[6];
    tbl = '{'{4, 1, 3, 1, 3, 3}, '{3, 5, 2, 2, 1, 2}, '{2, 0, 2, 0, 2, 2},
            '{1, 1, 1, 0, 1, 1}, '{5, 4, 1, 4, 1, 1}, '{3, 3, 4, 2, 1, 4}};
    repeat (3) @(negedge clk);
    chk("reset", mk(1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      chk("period0_start", mk(1'b0, 1'b0, 1'b0, 0));
      @(negedge clk);
    end
    cfg(4, 1, 1);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) begin
      chk("idle_start_stop", mk(1'b0, 1'b0, 1'b0, 0));
      @(negedge clk);
    end
    foreach (tbl[i]) begin
      cfg(tbl[i].period, tbl[i].width, tbl[i].count);
      run($sformatf("vec%0d", i), tbl[i].hi, tbl[i].lo, tbl[i].n, 0, -1, -1, -1, 0);
    end
    cfg(4, 2, 0);
    run("cont_stop_high", 2, 2, 0, 0, 82, -1, -1, 0);
    run("busy_start_stop", 2, 2, 0, 0, 13, 13, -1, 0);
    cfg(4, 1, 2);
    run("busy_start_ignored", 1, 3, 2, 0, -1, 5, -1, 0);
    run("width_rewrite_cur", 1, 3, 2, 0, -1, -1, 3, 3);
    run("width_rewrite_next", 3, 1, 2, 0, -1, -1, -1, 0);
    cfg(1, 0, 0);
    run("cnt_saturate", 0, 1, 0, 0, 520, -1, -1, 0);
`ifdef PULSE_GEN_DELAY_EN
    cfg(4, 1, 1);
    wr(2'd3, 5);
    run("delay5", 1, 3, 1, 10, -1, -1, -1, 0);
    wr(2'd3, 0);
`else
    cfg(4, 1, 1);
    wr(2'd3, 5);
    run("delay_noop", 1, 3, 1, 0, -1, -1, -1, 0);
`endif
    cfg(4, 2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset", mk(1'b1, 1'b1, 1'b0, 1));
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid", mk(1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset", mk(1'b0, 1'b0, 1'b0, 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning system clocks per timing tick (range 1..65535).
REQ-002 SHALL have parameter W, default 8, meaning width of the PERIOD, WIDTH and COUNT config registers and of pulse_cnt.
REQ-003 SHALL have port clk  in  1  system clock, the same clock that drives the UART receiver and config RAM.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_we  in  1  config byte write strobe, one cycle per byte.
REQ-006 SHALL have port cfg_addr  in  2  config register select: 0 PERIOD, 1 WIDTH, 2 COUNT, 3 DELAY.
REQ-007 SHALL have port cfg_data  in  W  config byte, taken from the received UART byte.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a pulse train.
REQ-009 SHALL have port stop  in  1  one-cycle request to abort the train.
REQ-010 SHALL have port pulse_out  out  1  optical sync pulse drive.
REQ-011 SHALL have port busy  out  1  high while a train is running.
REQ-012 SHALL have port done  out  1  one-cycle strobe at the end of a train.
REQ-013 SHALL have port pulse_cnt  out  W  number of pulses emitted in the current or last train.

Function
REQ-014 SHALL update the config register selected by cfg_addr with cfg_data on each cfg_we cycle, including while busy.
REQ-015 SHALL copy PERIOD, WIDTH, COUNT and DELAY into shadow registers on an accepted start; the running train SHALL use only the shadow copies.
REQ-016 SHALL derive a tick from a prescaler that asserts for one clk every CLK_DIV clocks; the prescaler SHALL clear on an accepted start.
REQ-017 SHALL implement the FSM states IDLE, DELAY, HIGH, LOW and FIN.
REQ-018 SHALL move from IDLE to DELAY on start when busy=0 and PERIOD!=0.
REQ-019 SHALL ignore start when PERIOD=0, and SHALL ignore start while busy.
REQ-020 SHALL leave DELAY after DELAY ticks and go to HIGH; with DELAY=0 it SHALL go to HIGH on the next clk.
REQ-021 SHALL hold HIGH for WIDTH ticks, with pulse_out=1 and pulse_cnt incremented on HIGH entry.
REQ-022 SHALL hold LOW for PERIOD-WIDTH ticks, after which it returns to HIGH or goes to FIN.
REQ-023 SHALL clamp WIDTH to PERIOD-1 when WIDTH>=PERIOD.
REQ-024 SHALL, when WIDTH=0, keep pulse_out=0, still count periods, and spend the whole period in LOW.
REQ-025 SHALL go from LOW to FIN when pulse_cnt equals COUNT; COUNT=0 SHALL mean continuous operation until stop.
REQ-026 SHALL saturate pulse_cnt at 2^W-1 without wrapping.
REQ-027 SHALL, in FIN, assert done for one clk, then return to IDLE with busy=0.
REQ-028 SHALL, on stop in any non-IDLE state, drive pulse_out=0 in the next clk and go to FIN, truncating a HIGH in progress.
REQ-029 SHALL give stop priority when start and stop arrive in the same cycle; in IDLE the pair SHALL be ignored.
REQ-030 SHALL register pulse_out, busy and done, giving a latency of 1 clk after the FSM state changes.

Reset
REQ-031 SHALL, while rst=1, force: state IDLE, pulse_out 0, busy 0, done 0, pulse_cnt 0, prescaler 0, PERIOD 0, WIDTH 0, COUNT 0, DELAY 0.
REQ-032 SHALL, on rst during a train, drop pulse_out in the next clk and SHALL NOT emit done.

Configuration
REQ-033 SHALL provide the macro PULSE_GEN_DELAY_EN.
REQ-034 SHALL, when PULSE_GEN_DELAY_EN is defined, support the DELAY register and the DELAY state.
REQ-035 SHALL, when PULSE_GEN_DELAY_EN is undefined, omit the DELAY register and state, treat writes to address 3 as no-ops, and go from IDLE straight to HIGH on the next clk after start.

Structure
REQ-036 SHALL place the FSM state enum, the config address constants (ADDR_PERIOD, ADDR_WIDTH, ADDR_COUNT, ADDR_DELAY) and the default CLK_DIV in the shared package pulse_gen_pkg.
REQ-037 SHALL implement the prescaler as the sub-module tick_div, with parameter CLK_DIV, ports clk, rst, clr and output tick.

Verification
REQ-038 SHALL cover: CLK_DIV=2, PERIOD=4, WIDTH=1, COUNT=3, DELAY=0, start -> three 2-clk high pulses on an 8-clk period, pulse_cnt=3, done once, then busy=0.
REQ-039 SHALL cover: PERIOD=3, WIDTH=5 -> pulse_out high 2 ticks and low 1 tick per period (clamp applied).
REQ-040 SHALL cover: COUNT=0, run 10 periods, then stop during HIGH -> pulse_out=0 in the next clk, done one clk later, pulse_cnt=10 or 11 matching the pulses emitted.
REQ-041 SHALL cover: PERIOD=0 plus start -> busy stays 0; and start with stop in the same cycle while busy -> abort.
REQ-042 SHALL cover: WIDTH rewritten mid-train -> the current train is unchanged and the next train uses the new WIDTH.
REQ-043 SHALL cover: DELAY=5 with PULSE_GEN_DELAY_EN defined -> first rising edge 5 ticks plus 1 clk after start; rst mid-train -> every output returns to its reset value with no done.
